// File: rtl/johnson_ring_counter_gen.sv
// Shift-register sequencer: N-bit Johnson (period 2N) or one-hot ring (period N),
// with run-time direction, parallel load, illegal-state detection and phase decode.
module johnson_ring_counter_gen #(
  parameter int N            = 4,
  parameter bit SELF_CORRECT = 1'b1,
  localparam int PW          = $clog2(2 * N)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          enable,
  input  logic          mode,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_value,
  output logic [N-1:0]  dout,
  output logic [PW-1:0] phase,
  output logic          wrap,
  output logic          err
);

  logic [N-1:0] dout_q, dout_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;

  logic [N-1:0] home;
  logic [N-1:0] step;
  logic         legal;
  int           k;
  int           pos;
  int           trans;
  int           phase_val;

  assign home = mode ? '0 : {1'b1, {(N-1){1'b0}}};

  always_comb begin
    step = dout_q;
    case ({mode, dir})
      2'b11:   step = {dout_q[N-2:0], ~dout_q[N-1]};
      2'b10:   step = {~dout_q[0], dout_q[N-1:1]};
      2'b01:   step = {dout_q[N-2:0], dout_q[N-1]};
      default: step = {dout_q[0], dout_q[N-1:1]};
    endcase
  end

  // Johnson-legal patterns have at most one boundary between adjacent bits.
  always_comb begin
    k     = 0;
    pos   = 0;
    trans = 0;
    for (int i = 0; i < N; i++) begin
      if (dout_q[i]) begin
        k   = k + 1;
        pos = i;
      end
    end
    for (int i = 0; i < N - 1; i++) begin
      if (dout_q[i] != dout_q[i+1]) trans = trans + 1;
    end
  end

  assign legal = mode ? (trans <= 1) : (k == 1);

  always_comb begin
    phase_val = 0;
    if (legal) begin
      if (mode) begin
        if ((dir ? dout_q[0] : dout_q[N-1]) || (k == 0)) phase_val = k;
        else                                             phase_val = 2 * N - k;
      end else begin
        if (dir) phase_val = (pos + 1) % N;
        else     phase_val = N - 1 - pos;
      end
    end
  end

  assign phase = phase_val[PW-1:0];

  always_comb begin
    dout_d = dout_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      dout_d = load_value;
    end else if (enable) begin
      if (legal) begin
        dout_d = step;
        wrap_d = (step == home);
      end else begin
        err_d  = 1'b1;
        dout_d = SELF_CORRECT ? home : step;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      dout_q <= home;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign dout = dout_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule
